// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO of {pc, pc4, inst}
// entries with a valid/ready pop side, flush-on-redirect and empty/full status.
module inst_buffer #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [ADDR_WIDTH-1:0]   in_pc,
  input  logic [ADDR_WIDTH-1:0]   in_pc4,
  input  logic [INST_WIDTH-1:0]   in_inst,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [ADDR_WIDTH-1:0]   out_pc4,
  output logic [INST_WIDTH-1:0]   out_inst,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc4_mem  [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;
  logic wr_en;

  // DEPTH is a power of two, so natural overflow of the pointer is the wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  // Status decoded from the registered count only, never from this cycle's handshakes.
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = cnt;

  assign push  = in_valid && !full;
  assign pop   = out_valid && out_ready;
  assign wr_en = push && reset && !flush;

  // Storage is never reset; empty masks whatever it holds.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= in_pc;
      pc4_mem[wr_ptr]  <= in_pc4;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign out_pc   = empty ? '0       : pc_mem[rd_ptr];
  assign out_pc4  = empty ? '0       : pc4_mem[rd_ptr];
  assign out_inst = empty ? NOP_INST : inst_mem[rd_ptr];

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: stimulus queues expected entries, a negedge
// monitor checks every popped head entry and the requested status snapshots.
module tb_inst_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [63:0] in_pc4;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_pc4;
  logic [31:0] out_inst;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  inst_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_pc4(in_pc4), .in_inst(in_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    chk_req = 0;
  int    chk_done = 0;
  string e_tag;
  int    e_cnt;
  int    e_sb;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: consumes scoreboard entries on accepted pops, then services status requests.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (reset && !flush && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc %h want no entry (t=%0t)", out_pc, $time);
        end else begin
          e = sb.pop_front();
          cmp("pop_pc", out_pc, e.pc);
          cmp("pop_pc4", out_pc4, e.pc4);
          cmp("pop_inst", 64'(out_inst), 64'(e.inst));
        end
      end
      if (chk_req != chk_done) begin
        cmp({e_tag, "_count"}, 64'(count), 64'(e_cnt));
        cmp({e_tag, "_empty"}, 64'(empty), 64'(e_cnt == 0));
        cmp({e_tag, "_full"}, 64'(full), 64'(e_cnt == 4));
        cmp({e_tag, "_in_ready"}, 64'(in_ready), 64'(e_cnt != 4));
        cmp({e_tag, "_out_valid"}, 64'(out_valid), 64'(e_cnt != 0));
        if (e_cnt == 0) begin
          cmp({e_tag, "_nop_inst"}, 64'(out_inst), 64'h13);
          cmp({e_tag, "_zero_pc"}, out_pc, 64'h0);
          cmp({e_tag, "_zero_pc4"}, out_pc4, 64'h0);
        end
        if (e_sb >= 0) cmp({e_tag, "_sb_left"}, 64'(sb.size()), 64'(e_sb));
        chk_done = chk_req;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic rdy);
    in_valid  = v;
    in_pc     = pc;
    in_pc4    = pc + 64'd4;
    in_inst   = inst;
    out_ready = rdy;
  endtask

  task automatic expect_entry(input logic [63:0] pc, input logic [31:0] inst);
    ent_t e;
    e.pc   = pc;
    e.pc4  = pc + 64'd4;
    e.inst = inst;
    sb.push_back(e);
  endtask

  task automatic status(input string tag, input int c, input int s);
    e_tag = tag;
    e_cnt = c;
    e_sb  = s;
    chk_req++;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    cycle();
    cycle();
    reset = 1'b1;
    status("reset", 0, 0);
    cycle();

    // Fill to full, 5th push dropped both without and with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 32'hA + 32'(i), 1'b0);
      expect_entry(64'h1000 + 64'(4 * i), 32'hA + 32'(i));
      status("fill", i, -1);
      cycle();
    end
    drive(1'b1, 64'h1010, 32'hE, 1'b0);
    status("full", 4, -1);
    cycle();
    drive(1'b1, 64'h1010, 32'hE, 1'b1);
    status("full_pop", 4, -1);
    cycle();
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      status("drain", 3 - k, -1);
      cycle();
    end
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    status("drained", 0, 0);
    cycle();

    // Steady push+pop at count=2 so both pointers wrap repeatedly
    drive(1'b1, 64'h3000, 32'h30, 1'b0);
    expect_entry(64'h3000, 32'h30);
    status("wpre0", 0, -1);
    cycle();
    drive(1'b1, 64'h3004, 32'h31, 1'b0);
    expect_entry(64'h3004, 32'h31);
    status("wpre1", 1, -1);
    cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 64'h3008 + 64'(4 * k), 32'h32 + 32'(k), 1'b1);
      expect_entry(64'h3008 + 64'(4 * k), 32'h32 + 32'(k));
      status("wrap", 2, -1);
      cycle();
    end
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    status("wdrain2", 2, -1);
    cycle();
    status("wdrain1", 1, -1);
    cycle();
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    status("wend", 0, 0);
    cycle();

    // Flush with a concurrent push and pop request: everything discarded
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h4000 + 64'(4 * i), 32'h40 + 32'(i), 1'b0);
      status("fpre", i, -1);
      cycle();
    end
    drive(1'b1, 64'h2000, 32'h20, 1'b1);
    flush = 1'b1;
    status("flush", 3, -1);
    cycle();
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    status("postflush", 0, 0);
    cycle();
    drive(1'b1, 64'h2000, 32'h20, 1'b0);
    expect_entry(64'h2000, 32'h20);
    status("refetch", 0, -1);
    cycle();
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    status("refetch_out", 1, -1);
    cycle();
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    status("fend", 0, 0);
    cycle();

    // Reset mid-stream beats a concurrent push and pop
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h5000 + 64'(4 * i), 32'h50 + 32'(i), 1'b0);
      status("rpre", i, -1);
      cycle();
    end
    drive(1'b1, 64'h5008, 32'h52, 1'b1);
    reset = 1'b0;
    status("rmid", 2, -1);
    cycle();
    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    status("rpost", 0, 0);
    cycle();
    drive(1'b1, 64'h6000, 32'h60, 1'b1);
    expect_entry(64'h6000, 32'h60);
    status("after", 0, -1);
    cycle();
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    status("after1", 1, -1);
    cycle();
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    status("aend", 0, 0);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
